// File: rtl/shift_reg_param_if.sv
// Control/data bundle for the parametrised pattern shift register.
// The master side (game controller or bench) drives the controls, and the slave side (the register) returns its status.
interface shift_reg_param_if #(
    parameter int W  = 6,
    parameter int CW = 4
);
    logic [1:0]    mode;
    logic          bit_in;
    logic          step;
    logic          load;
    logic [W-1:0]  load_value;
    logic          burst_start;
    logic [CW-1:0] burst_len;
    logic [W-1:0]  reg_content;
    logic          bit_out;
    logic          busy;
    logic          done;

    modport master (
        output mode, bit_in, step, load, load_value, burst_start, burst_len,
        input  reg_content, bit_out, busy, done
    );

    modport slave (
        input  mode, bit_in, step, load, load_value, burst_start, burst_len,
        output reg_content, bit_out, busy, done
    );
endinterface

// File: rtl/shift_reg_param.sv
// W-bit shift/rotate register with parallel load and a counted burst mode.
// Every output is registered. A burst latches its mode but samples bit_in live on each step.
module shift_reg_param #(
    parameter int            W         = 6,
    parameter logic [W-1:0]  RST_VALUE = W'(1),
    parameter int            CW        = 4
) (
    input  logic                clk,
    input  logic                Rst,
    shift_reg_param_if.slave    bus
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_reg;
    logic [W-1:0]  data_reg;
    logic          bit_out_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    burst_mode_reg;

    logic [1:0]    op_mode;
    logic          fill_l;
    logic          fill_r;
    logic [W-1:0]  shl_vec;
    logic [W-1:0]  shr_vec;
    logic [W-1:0]  step_data;
    logic          step_bit;

    // A burst uses its latched mode. In IDLE the live mode applies.
    assign op_mode = (state_reg == BURST) ? burst_mode_reg : bus.mode;
    assign fill_l  = op_mode[1] ? data_reg[W-1] : bus.bit_in;
    assign fill_r  = op_mode[1] ? data_reg[0]   : bus.bit_in;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_lane
            if (gi == 0) begin : g_lsb
                assign shl_vec[gi] = fill_l;
            end else begin : g_mid_l
                assign shl_vec[gi] = data_reg[gi-1];
            end
            if (gi == W-1) begin : g_msb
                assign shr_vec[gi] = fill_r;
            end else begin : g_mid_r
                assign shr_vec[gi] = data_reg[gi+1];
            end
        end
    endgenerate

    assign step_data = op_mode[0] ? shr_vec : shl_vec;
    assign step_bit  = op_mode[0] ? data_reg[0] : data_reg[W-1];

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_reg      <= IDLE;
            data_reg       <= RST_VALUE;
            bit_out_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            count_reg      <= '0;
            burst_mode_reg <= 2'b00;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.load) begin
                        data_reg <= bus.load_value;
                    end else if (bus.burst_start) begin
                        if (bus.burst_len != '0) begin
                            state_reg      <= BURST;
                            busy_reg       <= 1'b1;
                            count_reg      <= bus.burst_len;
                            burst_mode_reg <= bus.mode;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end else if (bus.step) begin
                        data_reg    <= step_data;
                        bit_out_reg <= step_bit;
                    end
                end
                BURST: begin
                    if (bus.load) begin
                        // A load aborts the burst silently, so no done pulse follows.
                        data_reg  <= bus.load_value;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                    end else begin
                        data_reg    <= step_data;
                        bit_out_reg <= step_bit;
                        count_reg   <= count_reg - 1'b1;
                        if (count_reg == CW'(1)) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reg_content = data_reg;
    assign bus.bit_out     = bit_out_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;

endmodule
